// File: rtl/uart_tx_fifo_cfg_pkg.sv
// rtl/uart_tx_fifo_cfg_pkg.sv - shared UART constants, FSM encoding and bit-period helper
package uart_tx_fifo_cfg_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Shared with the receiver so both ends derive the same integer period.
    function automatic int bit_period(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous FIFO with occupancy count, refuses writes when full
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// rtl/uart_tx_fifo_cfg.sv - configurable UART transmitter (data bits, parity, stop bits) behind a TX FIFO
module uart_tx_fifo_cfg
    import uart_tx_fifo_cfg_pkg::*;
#(
    parameter int SYS_CLK_FREQ = 48_000_000,
    parameter int BAUD_RATE    = 9_600,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [DATA_BITS-1:0]          data_in,
    input  logic                          valid,
    output logic                          ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BIT_PERIOD = bit_period(SYS_CLK_FREQ, BAUD_RATE);
    localparam int STOP_LEN   = BIT_PERIOD * STOP_BITS;
    localparam int TW         = $clog2(STOP_LEN);
    localparam int BW         = $clog2(DATA_BITS);

    localparam logic [TW-1:0] BIT_RELOAD  = TW'(BIT_PERIOD - 1);
    localparam logic [TW-1:0] STOP_RELOAD = TW'(STOP_LEN - 1);
    localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_BITS - 1);
    localparam logic          HAS_PARITY  = (PARITY != PARITY_NONE);
    localparam logic          ODD_PARITY  = (PARITY == PARITY_ODD);

    if (BIT_PERIOD < 2) begin : g_err_baud
        $error("uart_tx_fifo_cfg: SYS_CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_err_data
        $error("uart_tx_fifo_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY != PARITY_NONE && PARITY != PARITY_EVEN && PARITY != PARITY_ODD) begin : g_err_parity
        $error("uart_tx_fifo_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_err_stop
        $error("uart_tx_fifo_cfg: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_err_depth
        $error("uart_tx_fifo_cfg: FIFO_DEPTH must be a power of two >= 2");
    end

    tx_state_t              state;
    logic [TW-1:0]          timer;
    logic [BW-1:0]          bit_idx;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [DATA_BITS-1:0]   head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   timer_done;
    logic                   pop;
    logic                   par_bit;
    logic                   line;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (valid),
        .wr_data (data_in),
        .rd_en   (pop),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign ready      = !fifo_full;
    assign timer_done = (timer == '0);
    assign par_bit    = (^shift_reg) ^ ODD_PARITY;
    // Popping at the end of STOP lets the next frame start with no idle gap.
    assign pop        = !fifo_empty &&
                        ((state == ST_IDLE) || (state == ST_STOP && timer_done));

    always_comb begin
        line = 1'b1;
        case (state)
            ST_START:  line = 1'b0;
            ST_DATA:   line = shift_reg[bit_idx];
            ST_PARITY: line = par_bit;
            default:   line = 1'b1;
        endcase
    end

    // tx and busy are registered from the current state, so the line lags the FSM by one cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
        end else begin
            tx   <= line;
            busy <= (state != ST_IDLE) || !fifo_empty;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        shift_reg <= head;
                        timer     <= BIT_RELOAD;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    if (timer_done) begin
                        timer   <= BIT_RELOAD;
                        bit_idx <= '0;
                        state   <= ST_DATA;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (!timer_done) begin
                        timer <= timer - 1'b1;
                    end else if (bit_idx != LAST_BIT) begin
                        timer   <= BIT_RELOAD;
                        bit_idx <= bit_idx + 1'b1;
                    end else if (HAS_PARITY) begin
                        timer <= BIT_RELOAD;
                        state <= ST_PARITY;
                    end else begin
                        timer <= STOP_RELOAD;
                        state <= ST_STOP;
                    end
                end
                ST_PARITY: begin
                    if (timer_done) begin
                        timer <= STOP_RELOAD;
                        state <= ST_STOP;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_STOP: begin
                    if (!timer_done) begin
                        timer <= timer - 1'b1;
                    end else if (pop) begin
                        shift_reg <= head;
                        timer     <= BIT_RELOAD;
                        state     <= ST_START;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_tx_fifo_cfg.md
Name: uart_tx_fifo_cfg

Overview:
Parametrised UART transmitter that succeeds the fixed 8N1 transmitter. Data width, parity mode and stop-bit count are configurable. A small transmit FIFO with a valid/ready handshake sits in front, so producers (command decoders, debug printers) can push bursts without polling busy. It sits between on-chip producers and the FPGA TX pin.

Parameters:
SYS_CLK_FREQ, 48_000_000, system clock in Hz
BAUD_RATE, 9_600, line rate; BIT_PERIOD = SYS_CLK_FREQ / BAUD_RATE (integer divide), must be >= 2
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, FIFO entries, power of two, >= 2

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
data_in  in  DATA_BITS  word to queue
valid  in  1  producer offers data_in this cycle
ready  out  1  FIFO can accept; a write occurs when valid && ready at a rising edge
tx  out  1  UART TX line, registered
busy  out  1  frame in progress OR FIFO non-empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries

Behaviour:
- Clock and reset: one clock, clk. Reset is reset_n, synchronous, active-low, sampled on the clk rising edge.
- Reset values: tx=1, busy=0, ready=1, fifo_count=0. FSM is IDLE, pointers and timer are 0.
- Reset mid-frame: the frame is abandoned, tx returns to 1 on the next edge and the FIFO is flushed.
- FIFO, write side: ready = (fifo_count != FIFO_DEPTH). A write with valid && ready is stored at that edge. valid with ready=0 is ignored, with no overflow.
- FIFO, read side: pointers wrap modulo FIFO_DEPTH.
- FIFO, simultaneous push and pop: when full, the push is still refused (ready is low). When the FIFO holds at least one entry, push and pop in the same cycle leave fifo_count unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx=1. If fifo_count != 0, pop the head into the shift register, set timer = BIT_PERIOD-1 and go to START.
- Latency: data written at edge N is popped at edge N+1 (FIFO empty, FSM idle). tx falls at edge N+2.
- START: tx=0 for BIT_PERIOD cycles.
- DATA: tx = shift_reg[bit_index], LSB first, BIT_PERIOD cycles per bit, for DATA_BITS bits. Then go to PARITY if PARITY != 0, else STOP.
- PARITY: tx = XOR of data bits (even) or its inverse (odd), held for BIT_PERIOD cycles.
- STOP: tx=1 for STOP_BITS*BIT_PERIOD cycles.
- End of STOP: if the FIFO is non-empty, pop and go directly to START on the same edge (no idle cycle between frames). Otherwise go to IDLE.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * BIT_PERIOD cycles exactly.
- busy: registered. It rises the cycle after the first accepted write and falls the cycle after the last stop bit completes with an empty FIFO.
- Timer width: $clog2(BIT_PERIOD*STOP_BITS). The timer is down-counting, and reload happens at 0.
- Illegal parameter values are rejected by a generate-time $error.

Decomposition:
- Shared package or include (uart_pkg.vh) holds:
  - PARITY_NONE/EVEN/ODD constants
  - FSM state encodings (3-bit)
  - a BIT_PERIOD helper macro, shared with the future configurable receiver
- One sub-module: uart_tx_fifo (synchronous FIFO, parametrised width and depth, ports wr_en/rd_en/count/full/empty).

Test Plan:
- Bench parameters for all cases: SYS_CLK_FREQ=800, BAUD_RATE=100, giving BIT_PERIOD=8.
- 8N1, push 0x55 -> tx low at edge N+2 for 8 cycles. Then bits 1,0,1,0,1,0,1,0, then high 8 cycles. Total 80 cycles; busy falls 1 cycle after.
- 8E1, push 0x07 -> parity bit 1 (three ones), 88-cycle frame. 8O1, same data -> parity bit 0.
- DATA_BITS=7, STOP_BITS=2, push 0x41 -> 7 data bits 1,0,0,0,0,0,1, stop held 16 cycles, total 80 cycles.
- FIFO_DEPTH=4, hold valid for 6 cycles with 0x10..0x15 -> 0x10 is popped immediately, so 5 writes are accepted (0x10..0x14). ready drops on the cycle after count reaches 4, and 0x15 is refused. 5 frames go out back-to-back with no idle gap.
- Assert reset_n=0 during the 3rd data bit -> tx=1 next edge, fifo_count=0, ready=1, busy=0. A new push after release produces a clean frame.
- Simultaneous push and pop at the end of STOP with count=1 -> count stays 1, next frame starts on the same edge.
